// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-type codes, FSM encodings and captured-flag payload for the branch resolve unit.
package branch_resolve_unit_pkg;

    localparam int unsigned BT_BEQ    = 0;
    localparam int unsigned BT_BNE    = 1;
    localparam int unsigned BT_BLT    = 2;
    localparam int unsigned BT_BGE    = 3;
    localparam int unsigned BT_BLTU   = 4;
    localparam int unsigned BT_BGEU   = 5;
    localparam int unsigned BT_ALWAYS = 6;
    localparam int unsigned BT_NEVER  = 7;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EVAL = 1'b1;

    // ALU flags captured on the request edge
    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // count up, stick at all-ones, clear has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: captures flags and type on request, evaluates one cycle later,
// pulses done/pc_write, keeps saturating statistics and a sticky busy-request error.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned BT_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_req,
    input  logic [BT_W-1:0]  br_type,
    input  logic             zero,
    input  logic             neg,
    input  logic             carry,
    input  logic             ovf,
    input  logic             abort,
    input  logic             cnt_clr,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             pc_write,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] tk_cnt,
    output logic             err
);

    logic [0:0]      state, state_nxt;
    logic [BT_W-1:0] bt_q, bt_nxt;
    alu_flags_t      flg_q, flg_nxt;
    logic            busy_nxt, done_nxt, taken_nxt, pc_write_nxt, err_nxt;
    logic            cond_c, br_inc_c, tk_inc_c;

    // condition select on the captured type and flags
    always_comb begin
        cond_c = 1'b0;
        case (bt_q)
            BT_W'(BT_BEQ):    cond_c = flg_q.zero;
            BT_W'(BT_BNE):    cond_c = ~flg_q.zero;
            BT_W'(BT_BLT):    cond_c = flg_q.neg ^ flg_q.ovf;
            BT_W'(BT_BGE):    cond_c = ~(flg_q.neg ^ flg_q.ovf);
            BT_W'(BT_BLTU):   cond_c = ~flg_q.carry;
            BT_W'(BT_BGEU):   cond_c = flg_q.carry;
            BT_W'(BT_ALWAYS): cond_c = 1'b1;
            BT_W'(BT_NEVER):  cond_c = 1'b0;
            default:          cond_c = 1'b0;
        endcase
    end

    // next-state, capture and output decode
    always_comb begin
        state_nxt    = state;
        bt_nxt       = bt_q;
        flg_nxt      = flg_q;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        taken_nxt    = taken;
        pc_write_nxt = 1'b0;
        br_inc_c     = 1'b0;
        tk_inc_c     = 1'b0;
        case (state)
            IDLE: begin
                if (br_req) begin
                    state_nxt = EVAL;
                    busy_nxt  = 1'b1;
                    bt_nxt    = br_type;
                    flg_nxt   = '{zero: zero, neg: neg, carry: carry, ovf: ovf};
                end
            end
            EVAL: begin
                state_nxt = IDLE;
                if (!abort) begin
                    done_nxt     = 1'b1;
                    taken_nxt    = cond_c;
                    pc_write_nxt = cond_c;
                    br_inc_c     = 1'b1;
                    tk_inc_c     = cond_c;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // a request seen while busy is dropped but flagged; clear wins
        if (err_clr) begin
            err_nxt = 1'b0;
        end else if (br_req && (state == EVAL)) begin
            err_nxt = 1'b1;
        end else begin
            err_nxt = err;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bt_q     <= '0;
            flg_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            taken    <= 1'b0;
            pc_write <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            bt_q     <= bt_nxt;
            flg_q    <= flg_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            taken    <= taken_nxt;
            pc_write <= pc_write_nxt;
            err      <= err_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_inc_c),
        .clr   (cnt_clr),
        .q     (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_tk_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (tk_inc_c),
        .clr   (cnt_clr),
        .q     (tk_cnt)
    );

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, multi-mode successor to the single-condition Branch/Zero gate in the multicycle datapath.
- Captures the ALU flags and the branch type in the branch-compare cycle, then evaluates one of eight conditions.
- Issues a one-cycle PC-source/PC-write pulse to the PC register.
- Keeps saturating branch and taken counters, plus a sticky error flag for requests that arrive while the unit is busy.

Parameters:
- CNT_W, 16, width of the branch and taken statistics counters (minimum 2).
- BT_W, 3, width of the branch-type code (fixed encoding below; upper codes are reserved if widened).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- br_req  in  1  request strobe from the control FSM in the branch-compare cycle.
- br_type  in  BT_W  condition select, sampled with br_req.
- zero  in  1  ALU zero flag, sampled with br_req.
- neg  in  1  ALU sign flag (result[31]), sampled with br_req.
- carry  in  1  ALU carry-out of A-B; 1 means no borrow (A>=B unsigned).
- ovf  in  1  ALU signed overflow, sampled with br_req.
- abort  in  1  cancels an in-flight evaluation (exception/flush).
- cnt_clr  in  1  synchronous clear of both counters.
- err_clr  in  1  synchronous clear of err.
- busy  out  1  high while in EVAL.
- done  out  1  one-cycle pulse when resolution completes.
- taken  out  1  resolved condition, drives PCSrc; valid while done=1.
- pc_write  out  1  one-cycle pulse equal to done & taken.
- br_cnt  out  CNT_W  resolved branches, saturating.
- tk_cnt  out  CNT_W  taken branches, saturating.
- err  out  1  sticky: a request arrived while busy.

Behaviour:
- Reset, applied asynchronously:
  - state = IDLE.
  - busy, done, taken, pc_write, err = 0.
  - br_cnt, tk_cnt = 0.
  - Captured flag and type registers = 0.
- Reset mid-EVAL discards the request; no done pulse follows.
- Condition encoding:
  - 0 BEQ: zero.
  - 1 BNE: !zero.
  - 2 BLT: neg ^ ovf.
  - 3 BGE: !(neg ^ ovf).
  - 4 BLTU: !carry.
  - 5 BGEU: carry.
  - 6 ALWAYS: 1.
  - 7 NEVER: 0.
  - Codes >7 (BT_W>3) evaluate to 0.
- FSM states: IDLE, EVAL.
  - IDLE: br_req=1 at edge k captures br_type and the flags; go to EVAL. busy=1 in the cycle after edge k.
  - EVAL, abort=0: at edge k+1 compute the condition from the captured values; go to IDLE; load done=1, taken=cond, pc_write=cond.
  - EVAL, abort=1: at edge k+1 go to IDLE; done, taken and pc_write stay 0; counters are unchanged.
- Latency: done/pc_write are visible in the cycle after edge k+1 (2 edges after the request).
- done and pc_write are single-cycle pulses. taken holds its last value until the next done; it is only meaningful while done=1.
- br_req while busy: the request is ignored (no capture, no extra pulse) and err is set at that edge.
- br_req in the same cycle that done=1 (state is IDLE): accepted normally. Back-to-back throughput is one branch per 2 cycles.
- Counters:
  - On each done, br_cnt increments by 1, and tk_cnt increments by 1 if taken.
  - Both saturate at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- err: err_clr has priority over a same-cycle set.
- Input flags are only observed on the request edge; changes during EVAL have no effect.

Decomposition:
- Shared package holds:
  - Branch-type localparams: BT_BEQ=0, BT_BNE=1, BT_BLT=2, BT_BGE=3, BT_BLTU=4, BT_BGEU=5, BT_ALWAYS=6, BT_NEVER=7.
  - FSM state encodings: IDLE=0, EVAL=1.
- One natural sub-module: sat_counter (parameter W; inputs inc and clr; clr wins; saturates at the maximum value). Instantiated twice, for br_cnt and tk_cnt.
- Condition evaluation stays inline as a combinational case.

Test Plan:
- Reset with no requests -> all outputs 0. Then BEQ with zero=1 -> done and pc_write high exactly 2 edges after the request, taken=1, br_cnt=1, tk_cnt=1.
- Sweep all 8 types against flag sets (zero,neg,carry,ovf) = (0,1,0,0) and (0,1,0,1):
  - BLT taken for the first set, not taken for the second; BGE the opposite.
  - BLTU taken for both (carry=0); BGEU not taken.
  - ALWAYS=1 and NEVER=0.
  - pc_write==taken on every done.
- br_req held high 4 consecutive cycles -> exactly 2 done pulses, err=1. Then err_clr asserted with a simultaneous busy request -> err=0.
- abort asserted in EVAL -> no done, no pc_write, counters unchanged. A following BNE with zero=0 resolves taken.
- CNT_W=2, 5 ALWAYS branches -> br_cnt and tk_cnt saturate at 3. cnt_clr on the same cycle as a done -> both read 0 afterwards.
- Asynchronous reset asserted mid-EVAL (between clock edges) -> outputs 0 immediately, no done pulse after release.
